// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt controller:
//   - irq_reg_e      : register index on the 2-bit address A
//   - STATUS_*       : bit positions inside the STATUS read word
//   - FILTER_CNT_W   : width of the per-channel glitch-filter counter
//   - id_w()         : width of the winning-channel ID, max(1, clog2(n))
// -----------------------------------------------------------------------------
package irq_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IRQ_PENDING = 2'd0,
      IRQ_MASK    = 2'd1,
      IRQ_MODE    = 2'd2,
      IRQ_STATUS  = 2'd3
   } irq_reg_e;

   // STATUS = {INT_REQ, 23'b0, IRQ_ID zero-extended to 8 bits}
   localparam int STATUS_INT_REQ_BIT = 31;
   localparam int STATUS_ID_LSB      = 0;
   localparam int STATUS_ID_W        = 8;

   localparam int FILTER_CNT_W = 8;

   function automatic int id_w(input int n_irq);
      return (n_irq > 1) ? $clog2(n_irq) : 1;
   endfunction

endpackage

// File: rtl/irq_sync_filter.sv
// -----------------------------------------------------------------------------
// irq_sync_filter
// One interrupt channel front end: SYNC_STAGES-deep synchroniser followed,
// when IRQ_GLITCH_FILTER_EN is defined, by a stability filter that moves the
// clean level only after the synchronised input has differed from it for
// FILTER_LEN consecutive cycles. Without the macro the clean level is the
// synchroniser output and no counter exists.
//
// Ports:
//   CLK    in  clock
//   RESET  in  asynchronous active-high reset
//   irq_i  in  raw request, asynchronous to CLK
//   lvl_o  out clean level, synchronous to CLK
// -----------------------------------------------------------------------------
module irq_sync_filter
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic irq_i,
   output logic lvl_o
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_param
      $error("irq_sync_filter: SYNC_STAGES or FILTER_LEN out of range");
   end

   logic [SYNC_STAGES-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the synchroniser chain into a single flop.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      end
   end

`ifdef IRQ_GLITCH_FILTER_EN
   localparam logic [FILTER_CNT_W-1:0] CNT_MAX = FILTER_CNT_W'(FILTER_LEN - 1);

   logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;
   logic                    filt_lvl_q, filt_lvl_d;

   // Count consecutive cycles where the synchronised input disagrees with
   // the clean level; the FILTER_LEN-th disagreement flips the level. Any
   // agreement (reversion) restarts the count from zero.
   always_comb begin
      cnt_d      = '0;
      filt_lvl_d = filt_lvl_q;
      if (sync_q[SYNC_STAGES-1] != filt_lvl_q) begin
         if (cnt_q == CNT_MAX) begin
            filt_lvl_d = sync_q[SYNC_STAGES-1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q      <= '0;
         filt_lvl_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         filt_lvl_q <= filt_lvl_d;
      end
   end

   assign lvl_o = filt_lvl_q;
`else
   assign lvl_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// N_IRQ-channel maskable interrupt controller feeding CP0. Each channel is
// synchronised (optionally glitch-filtered, macro IRQ_GLITCH_FILTER_EN),
// edge- or level-mode, and combined through a fixed-priority encoder where
// the lowest active index wins.
//
// Register window (A):
//   0 PENDING  R/W1C  edge channels: latched bits; level channels: live lvl
//   1 MASK     RW     1 = enabled
//   2 MODE     RW     1 = edge, 0 = level
//   3 STATUS   R: {INT_REQ, 23'b0, IRQ_ID[7:0]}  W: W1S into edge pending bits
//
// Ports:
//   CLK, RESET   clock, asynchronous active-high reset
//   IRQ_IN       raw requests, asynchronous
//   WE, A, WD    register write strobe, index, data
//   RD           combinational read data
//   ACK          CP0 interrupt-entry acknowledge (single-cycle pulse)
//   INT_REQ      registered interrupt request to CP0
//   IRQ_ID       registered winning channel index (holds when idle)
// -----------------------------------------------------------------------------
module irq_ctrl
   import irq_pkg::*;
#(
   parameter  int N_IRQ       = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int FILTER_LEN  = 4,
   localparam int ID_W        = id_w(N_IRQ)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [N_IRQ-1:0]  IRQ_IN,
   input  logic              WE,
   input  logic [1:0]        A,
   input  logic [DATA_W-1:0] WD,
   output logic [DATA_W-1:0] RD,
   input  logic              ACK,
   output logic              INT_REQ,
   output logic [ID_W-1:0]   IRQ_ID
);

   if (N_IRQ < 1 || N_IRQ > 32) begin : g_bad_n_irq
      $error("irq_ctrl: N_IRQ out of range");
   end

   logic [N_IRQ-1:0] lvl, lvl_d_q, edge_det;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] mode_q, mode_d;
   logic [N_IRQ-1:0] w1c, w1s, ack_clr;
   logic [N_IRQ-1:0] eff_pend, act;
   logic [N_IRQ-1:0] wd_n;
   logic             ack_q;
   logic [ID_W-1:0]  ack_id_q;
   logic             int_req_q, int_req_d;
   logic [ID_W-1:0]  irq_id_q, irq_id_d, win_id;

   // Data bits at and above N_IRQ are ignored on write.
   logic unused_wd;
   assign unused_wd = ^WD;
   assign wd_n      = WD[N_IRQ-1:0];

   // ---------------------------------------------------------------- channels
   for (genvar i = 0; i < N_IRQ; i++) begin : g_ch
      irq_sync_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_sync_filter (
         .CLK   (CLK),
         .RESET (RESET),
         .irq_i (IRQ_IN[i]),
         .lvl_o (lvl[i])
      );
   end

   assign edge_det = lvl & ~lvl_d_q;

   // --------------------------------------------------------- register writes
   // NOTE: every signal assigned in this always_comb gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      w1c    = '0;
      w1s    = '0;
      if (WE) begin
         unique case (irq_reg_e'(A))
            IRQ_PENDING: w1c    = wd_n & mode_q;  // level bits ignore W1C
            IRQ_MASK:    mask_d = wd_n;
            IRQ_MODE:    mode_d = wd_n;
            IRQ_STATUS:  w1s    = wd_n & mode_q;  // software trigger, edge only
         endcase
      end
   end

   // ACK is registered together with the ID CP0 saw, so the clear lands one
   // edge later and INT_REQ/IRQ_ID move two edges after ACK is sampled.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (ack_q && (ack_id_q == ID_W'(i))) begin
            ack_clr[i] = mode_q[i];
         end
      end
   end

   // Sets are OR-ed in after clears: a new edge or a W1S beats W1C/ACK on the
   // same bit. Level-mode channels keep their stored bit untouched.
   assign pend_d = (pend_q & ~(w1c | ack_clr)) | (edge_det & mode_q) | w1s;

   // -------------------------------------------------------- priority encode
   assign eff_pend = (mode_q & pend_q) | (~mode_q & lvl);
   assign act      = eff_pend & mask_q;

   always_comb begin
      win_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (act[i]) begin
            win_id = ID_W'(i);
         end
      end
   end

   assign int_req_d = |act;
   assign irq_id_d  = (|act) ? win_id : irq_id_q;

   // ------------------------------------------------------------- state
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lvl_d_q   <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         mode_q    <= '0;
         ack_q     <= 1'b0;
         ack_id_q  <= '0;
         int_req_q <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         lvl_d_q   <= lvl;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         ack_q     <= ACK;
         ack_id_q  <= irq_id_q;
         int_req_q <= int_req_d;
         irq_id_q  <= irq_id_d;
      end
   end

   assign INT_REQ = int_req_q;
   assign IRQ_ID  = irq_id_q;

   // --------------------------------------------------------------- read mux
   always_comb begin
      RD = '0;
      unique case (irq_reg_e'(A))
         IRQ_PENDING: RD[N_IRQ-1:0] = eff_pend;
         IRQ_MASK:    RD[N_IRQ-1:0] = mask_q;
         IRQ_MODE:    RD[N_IRQ-1:0] = mode_q;
         IRQ_STATUS: begin
            RD[STATUS_INT_REQ_BIT]            = int_req_q;
            RD[STATUS_ID_LSB +: STATUS_ID_W] = STATUS_ID_W'(irq_id_q);
         end
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl. Expected values are queued when stimulus
// is applied and popped in order when the corresponding output is sampled.
// With IRQ_GLITCH_FILTER_EN defined, latencies grow by FILTER_LEN and the
// filter-specific scenarios run as well.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
   import irq_pkg::*;

   localparam int N_IRQ       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 4;
   localparam int ID_W        = id_w(N_IRQ);
`ifdef IRQ_GLITCH_FILTER_EN
   localparam int FL = FILTER_LEN;
`else
   localparam int FL = 0;
`endif

   logic              CLK;
   logic              RESET;
   logic [N_IRQ-1:0]  IRQ_IN;
   logic              WE;
   logic [1:0]        A;
   logic [31:0]       WD;
   logic [31:0]       RD;
   logic              ACK;
   logic              INT_REQ;
   logic [ID_W-1:0]   IRQ_ID;

   irq_ctrl #(
      .N_IRQ       (N_IRQ),
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .IRQ_IN  (IRQ_IN),
      .WE      (WE),
      .A       (A),
      .WD      (WD),
      .RD      (RD),
      .ACK     (ACK),
      .INT_REQ (INT_REQ),
      .IRQ_ID  (IRQ_ID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   // ------------------------------------------------------------ checking
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic score(input logic [31:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: got 0x%08h expected no output", obs);
      end else begin
         it = sb_q.pop_front();
         check(it.tag, obs, it.exp);
      end
   endtask

   // ------------------------------------------------------------ drivers
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr_reg(input logic [1:0] idx, input logic [31:0] data);
      WE = 1'b1;
      A  = idx;
      WD = data;
      tick();
      WE = 1'b0;
      WD = '0;
   endtask

   task automatic rd_reg(input logic [1:0] idx, output logic [31:0] val);
      A = idx;
      #1;
      val = RD;
   endtask

   task automatic pulse_ack();
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
   endtask

   function automatic logic [31:0] ireq();
      return {31'b0, INT_REQ};
   endfunction

   function automatic logic [31:0] iid();
      return 32'(IRQ_ID);
   endfunction

   // ------------------------------------------------------------ stimulus
   logic [31:0] v;

   initial begin
      RESET  = 1'b1;
      IRQ_IN = '0;
      WE     = 1'b0;
      A      = '0;
      WD     = '0;
      ACK    = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;

      // Reset state
      for (int idx = 0; idx < 4; idx++) begin
         expect_out($sformatf("reset_rd%0d", idx), 32'h0);
         rd_reg(2'(idx), v);
         score(v);
      end
      expect_out("reset_int_req", 32'h0);
      expect_out("reset_irq_id", 32'h0);
      score(ireq());
      score(iid());

      // Edge latch: INT_REQ rises exactly 3 edges after first sampling
      wr_reg(IRQ_MASK, 32'h0C);
      wr_reg(IRQ_MODE, 32'hFF);
      expect_out("edge_int_req_early", 32'h0);
      expect_out("edge_int_req", 32'h1);
      expect_out("edge_irq_id", 32'h3);
      IRQ_IN[3] = 1'b1;
      tick_n(3 + FL);
      IRQ_IN[3] = 1'b0;
      score(ireq());
      tick();
      score(ireq());
      score(iid());

      // Acknowledge: INT_REQ drops two edges after ACK is sampled
      expect_out("ack_int_req_hold", 32'h1);
      expect_out("ack_int_req_drop", 32'h0);
      expect_out("ack_pending", 32'h0);
      pulse_ack();
      tick();
      score(ireq());
      tick();
      score(ireq());
      rd_reg(IRQ_PENDING, v);
      score(v);

      // Priority: channels 5 and 2 together
      wr_reg(IRQ_MASK, 32'hFF);
      expect_out("prio_irq_id_2", 32'h2);
      expect_out("prio_int_req", 32'h1);
      IRQ_IN = 8'h24;
      tick_n(4 + FL);
      IRQ_IN = '0;
      score(iid());
      score(ireq());
      expect_out("prio_irq_id_5", 32'h5);
      expect_out("prio_int_req_5", 32'h1);
      pulse_ack();
      tick_n(2);
      score(iid());
      score(ireq());
      expect_out("prio_int_req_idle", 32'h0);
      expect_out("prio_irq_id_hold", 32'h5);
      pulse_ack();
      tick_n(2);
      score(ireq());
      score(iid());

      // Level channel: W1C and ACK do not clear it
      wr_reg(IRQ_MODE, 32'h00);
      wr_reg(IRQ_MASK, 32'h01);
      expect_out("lvl_int_req", 32'h1);
      expect_out("lvl_irq_id", 32'h0);
      IRQ_IN[0] = 1'b1;
      tick_n(3 + FL);
      score(ireq());
      score(iid());
      expect_out("lvl_after_w1c_ack", 32'h1);
      expect_out("lvl_pending_read", 32'h1);
      wr_reg(IRQ_PENDING, 32'h01);
      pulse_ack();
      tick_n(2);
      score(ireq());
      rd_reg(IRQ_PENDING, v);
      score(v);
      expect_out("lvl_deassert_hold", 32'h1);
      expect_out("lvl_deassert_drop", 32'h0);
      IRQ_IN[0] = 1'b0;
      tick_n(2 + FL);
      score(ireq());
      tick();
      score(ireq());

      // Collision: new edge on channel 1 with W1C of bit 1 in the same cycle
      wr_reg(IRQ_MODE, 32'hFF);
      wr_reg(IRQ_MASK, 32'h00);
      expect_out("collide_edge_w1c", 32'h2);
      IRQ_IN[1] = 1'b1;
      tick_n(2 + FL);
      wr_reg(IRQ_PENDING, 32'h02);
      rd_reg(IRQ_PENDING, v);
      score(v & 32'h2);
      IRQ_IN[1] = 1'b0;
      expect_out("w1c_clears", 32'h0);
      wr_reg(IRQ_PENDING, 32'hFF);
      rd_reg(IRQ_PENDING, v);
      score(v);

      // Software trigger through STATUS
      wr_reg(IRQ_MASK, 32'h80);
      expect_out("sw_trig_int_req", 32'h1);
      expect_out("sw_trig_irq_id", 32'h7);
      expect_out("status_read", 32'h8000_0007);
      wr_reg(IRQ_STATUS, 32'h80);
      tick();
      score(ireq());
      score(iid());
      rd_reg(IRQ_STATUS, v);
      score(v);

      // W1S in the same cycle as the ACK clear: bit stays set
      expect_out("w1s_ack_pending", 32'h80);
      expect_out("w1s_ack_int_req", 32'h1);
      pulse_ack();
      wr_reg(IRQ_STATUS, 32'h80);
      rd_reg(IRQ_PENDING, v);
      score(v);
      tick();
      score(ireq());

      // Bits above N_IRQ read 0
      expect_out("mask_upper_bits", 32'hFF);
      wr_reg(IRQ_MASK, 32'hFFFF_FFFF);
      rd_reg(IRQ_MASK, v);
      score(v);

      // Reset mid-operation clears everything at once
      expect_out("rst_int_req", 32'h0);
      expect_out("rst_irq_id", 32'h0);
      expect_out("rst_pending", 32'h0);
      expect_out("rst_mask", 32'h0);
      IRQ_IN[4] = 1'b1;
      tick_n(2);
      #2 RESET = 1'b1;
      #1;
      score(ireq());
      score(iid());
      IRQ_IN = '0;
      tick();
      RESET = 1'b0;
      rd_reg(IRQ_PENDING, v);
      score(v);
      rd_reg(IRQ_MASK, v);
      score(v);
      expect_out("rst_no_replay_int_req", 32'h0);
      expect_out("rst_no_replay_pending", 32'h0);
      wr_reg(IRQ_MASK, 32'h10);
      wr_reg(IRQ_MODE, 32'h10);
      tick_n(8 + FL);
      score(ireq());
      rd_reg(IRQ_PENDING, v);
      score(v);

`ifdef IRQ_GLITCH_FILTER_EN
      // Short pulse is rejected by the filter
      expect_out("filt_short_pending", 32'h0);
      expect_out("filt_short_int_req", 32'h0);
      IRQ_IN[4] = 1'b1;
      tick_n(3);
      IRQ_IN[4] = 1'b0;
      tick_n(12);
      rd_reg(IRQ_PENDING, v);
      score(v);
      score(ireq());

      // Long pulse passes
      expect_out("filt_long_pending", 32'h10);
      expect_out("filt_long_int_req", 32'h1);
      IRQ_IN[4] = 1'b1;
      tick_n(6);
      IRQ_IN[4] = 1'b0;
      tick_n(12);
      rd_reg(IRQ_PENDING, v);
      score(v);
      score(ireq());
`endif

      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_leftover: got %0d unchecked entries expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
